// File: rtl/rv_divide_seq.sv
// Radix-2 restoring divide sequencer for RV32M DIV/DIVU/REM/REMU.
// Define RV_DIV_EARLY_OUT_EN to short-cut divide-by-zero and signed overflow.
module rv_divide_seq #(
  parameter int ITERS = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        x_start_i,
  input  logic [2:0]  x_fun_i,
  input  logic        x_kill_i,
  input  logic [31:0] x_rs1_i,
  input  logic [31:0] x_rs2_i,
  output logic        x_stall_req_o,
  output logic        x_busy_o,
  output logic        w_done_o,
  output logic [31:0] w_result_o
);
  localparam int CW = $clog2(ITERS);

  typedef enum logic [2:0] {
    IDLE, PREP, DIVIDE, FIXUP, DONE
  } state_t;

  state_t state, state_nx;

  logic [31:0]   quo, rem, dvs;
  logic [1:0]    fun;
  logic          qneg, rneg, dz;
  logic [CW-1:0] cnt;

  logic        go, sgn, ge, last, early;
  logic [32:0] shifted;
  logic [31:0] diff, abs_a, abs_b;
  logic [31:0] q_fix, r_fix;

  assign go    = x_start_i && !x_kill_i && x_fun_i[2];
  assign sgn   = !fun[0];
  assign abs_a = (sgn && quo[31]) ? -quo : quo;
  assign abs_b = (sgn && dvs[31]) ? -dvs : dvs;

  // rem < dvs always holds, so a successful subtract fits in 32 bits
  assign shifted = {rem, quo[31]};
  assign ge      = shifted >= {1'b0, dvs};
  assign diff    = shifted[31:0] - dvs;
  assign last    = cnt == CW'(ITERS - 1);

  assign q_fix = (qneg && !dz) ? -quo : quo;
  assign r_fix = rneg ? -rem : rem;

`ifdef RV_DIV_EARLY_OUT_EN
  logic dz_now, ovf;
  assign dz_now = dvs == 32'd0;
  assign ovf    = sgn && quo == 32'h8000_0000
               && dvs == 32'hFFFF_FFFF;
  assign early  = dz_now || ovf;
`else
  assign early  = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:   if (go) state_nx = PREP;
      PREP: begin
        if (x_kill_i)   state_nx = IDLE;
        else if (early) state_nx = FIXUP;
        else            state_nx = DIVIDE;
      end
      DIVIDE: begin
        if (x_kill_i)  state_nx = IDLE;
        else if (last) state_nx = FIXUP;
      end
      FIXUP:  state_nx = x_kill_i ? IDLE : DONE;
      DONE:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      quo        <= '0;
      rem        <= '0;
      dvs        <= '0;
      fun        <= '0;
      qneg       <= 1'b0;
      rneg       <= 1'b0;
      dz         <= 1'b0;
      cnt        <= '0;
      w_done_o   <= 1'b0;
      w_result_o <= '0;
    end else begin
      w_done_o <= state == FIXUP && !x_kill_i;
      unique case (state)
        IDLE: begin
          if (go) begin
            quo <= x_rs1_i;
            dvs <= x_rs2_i;
            fun <= x_fun_i[1:0];
          end
        end
        PREP: begin
          quo  <= abs_a;
          dvs  <= abs_b;
          qneg <= sgn && (quo[31] ^ dvs[31]);
          rneg <= sgn && quo[31];
          dz   <= dvs == 32'd0;
          rem  <= '0;
          cnt  <= '0;
`ifdef RV_DIV_EARLY_OUT_EN
          if (dz_now) begin
            quo  <= 32'hFFFF_FFFF;
            rem  <= quo;
            qneg <= 1'b0;
            rneg <= 1'b0;
          end else if (ovf) begin
            quo  <= 32'h8000_0000;
            rem  <= '0;
            qneg <= 1'b0;
            rneg <= 1'b0;
          end
`endif
        end
        DIVIDE: begin
          rem <= ge ? diff : shifted[31:0];
          quo <= {quo[30:0], ge};
          cnt <= cnt + 1'b1;
        end
        FIXUP: begin
          if (!x_kill_i)
            w_result_o <= fun[1] ? r_fix : q_fix;
        end
        default: ;
      endcase
    end
  end

  assign x_busy_o = state != IDLE;

  // gated by reset so a held start cannot stall while in reset
  assign x_stall_req_o = !rst_i && (
      (state == IDLE && go)
    || state == PREP
    || state == DIVIDE
    || state == FIXUP);

endmodule

// File: tb/tb_rv_divide_seq.sv
// Directed bench for rv_divide_seq: vector table plus kill,
// kill-in-DONE and asynchronous reset sequences.
module tb_rv_divide_seq;
  logic        clk = 1'b0;
  logic        rst, start, kill;
  logic [2:0]  fun;
  logic [31:0] rs1, rs2;
  logic        stall, busy, done;
  logic [31:0] result;

`ifdef RV_DIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  rv_divide_seq #(.ITERS(32)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .x_start_i(start),
    .x_fun_i(fun),
    .x_kill_i(kill),
    .x_rs1_i(rs1),
    .x_rs2_i(rs2),
    .x_stall_req_o(stall),
    .x_busy_o(busy),
    .w_done_o(done),
    .w_result_o(result)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]  fun;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    bit          corner;
  } vec_t;

  vec_t vecs[16];

  task automatic run_op(input string nm,
                        input logic [2:0] f,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [31:0] res,
                        input int lat);
    int n;
    int st;
    @(negedge clk);
    start = 1'b1;
    fun   = f;
    rs1   = a;
    rs2   = b;
    kill  = 1'b0;
    #1;
    check({nm, " stall@start"}, 32'(stall), 32'd1);
    @(negedge clk);
    start = 1'b0;
    n  = 1;
    st = 0;
    check({nm, " busy"}, 32'(busy), 32'd1);
    while (!done && n < 100) begin
      if (stall) st++;
      @(negedge clk);
      n++;
    end
    if (!done) begin
      check({nm, " timeout"}, 32'(done), 32'd1);
    end else begin
      check({nm, " latency"}, 32'(n), 32'(lat));
      check({nm, " stall_cycles"}, 32'(st), 32'(lat - 1));
      check({nm, " stall@done"}, 32'(stall), 32'd0);
      check({nm, " result"}, result, res);
      @(negedge clk);
      check({nm, " done_pulse"}, 32'(done), 32'd0);
      check({nm, " idle"}, 32'(busy), 32'd0);
      check({nm, " hold"}, result, res);
    end
  endtask

  initial begin
    int n;
    int lat;
    logic [31:0] held;

    vecs[0]  = '{3'd5, 32'd100,        32'd7,        32'd14,         1'b0};
    vecs[1]  = '{3'd7, 32'd100,        32'd7,        32'd2,          1'b0};
    vecs[2]  = '{3'd6, 32'hFFFF_FF9C,  32'd7,        32'hFFFF_FFFE,  1'b0};
    vecs[3]  = '{3'd4, 32'hFFFF_FF9C,  32'd7,        32'hFFFF_FFF2,  1'b0};
    vecs[4]  = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
    vecs[5]  = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1'b1};
    vecs[6]  = '{3'd5, 32'd5,          32'd0,        32'hFFFF_FFFF,  1'b1};
    vecs[7]  = '{3'd7, 32'd5,          32'd0,        32'd5,          1'b1};
    vecs[8]  = '{3'd4, 32'hFFFF_FFFB,  32'd0,        32'hFFFF_FFFF,  1'b1};
    vecs[9]  = '{3'd6, 32'hFFFF_FFFB,  32'd0,        32'hFFFF_FFFB,  1'b1};
    vecs[10] = '{3'd5, 32'hFFFF_FFFF,  32'd1,        32'hFFFF_FFFF,  1'b0};
    vecs[11] = '{3'd4, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0};
    vecs[12] = '{3'd6, 32'd7,          32'hFFFF_FFFE, 32'd1,         1'b0};
    vecs[13] = '{3'd5, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1'b0};
    vecs[14] = '{3'd7, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b0};
    vecs[15] = '{3'd4, 32'h8000_0000,  32'd2,        32'hC000_0000,  1'b0};

    rst   = 1'b1;
    start = 1'b1;
    kill  = 1'b0;
    fun   = 3'd5;
    rs1   = 32'd1;
    rs2   = 32'd1;
    repeat (3) @(negedge clk);
    check("rst stall", 32'(stall), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst result", result, 32'd0);
    start = 1'b0;
    rst   = 1'b0;

    for (int i = 0; i < 16; i++) begin
      lat = (vecs[i].corner && EARLY) ? 3 : 35;
      run_op($sformatf("vec%0d", i), vecs[i].fun,
             vecs[i].a, vecs[i].b, vecs[i].res, lat);
    end
    held = vecs[15].res;

    // kill at cycle 10 of a DIV
    @(negedge clk);
    start = 1'b1;
    fun   = 3'd4;
    rs1   = 32'd1000;
    rs2   = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("kill busy_before", 32'(busy), 32'd1);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    check("kill busy", 32'(busy), 32'd0);
    check("kill stall", 32'(stall), 32'd0);
    n = 0;
    repeat (40) begin
      if (done) n++;
      @(negedge clk);
    end
    check("kill no_done", 32'(n), 32'd0);
    check("kill result_held", result, held);
    run_op("after_kill", 3'd5, 32'd9, 32'd3, 32'd3, 35);

    // kill while in DONE must not disturb the pulse
    @(negedge clk);
    start = 1'b1;
    fun   = 3'd5;
    rs1   = 32'd50;
    rs2   = 32'd6;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    kill = 1'b1;
    #1;
    check("done_kill done", 32'(done), 32'd1);
    check("done_kill result", result, 32'd8);
    @(negedge clk);
    kill = 1'b0;
    check("done_kill idle", 32'(busy), 32'd0);
    check("done_kill result_held", result, 32'd8);

    // async reset mid-DIVIDE
    @(negedge clk);
    start = 1'b1;
    fun   = 3'd4;
    rs1   = 32'd12345;
    rs2   = 32'd11;
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    check("arst busy_before", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst busy", 32'(busy), 32'd0);
    check("arst stall", 32'(stall), 32'd0);
    check("arst done", 32'(done), 32'd0);
    check("arst result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op("after_rst", 3'd7, 32'd100, 32'd7, 32'd2, 35);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
